// File: rtl/seven_segment_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : seven_segment_scanner
//  Description : Time-multiplexed scanner for a NUM_DIGITS seven-segment
//                display. Each digit gets an all-off guard interval and then
//                a show interval. New values are double-buffered and are
//                applied only at frame boundaries. Leading-zero blanking and
//                output polarity are selectable at run time.
//  Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scanner #(
   parameter int NUM_DIGITS   = 4,
   parameter int SHOW_CYCLES  = 50000,
   parameter int GUARD_CYCLES = 1000
) (
   input  logic                      i_CLK,
   input  logic                      i_RESET,
   input  logic                      i_LOAD,
   input  logic [4*NUM_DIGITS-1:0]   i_VALUE,
   input  logic [NUM_DIGITS-1:0]     i_DOT_MASK,
   input  logic                      i_BLANK_LEADING,
   input  logic                      i_COMMON_ANOD,
   output logic [3:0]                o_DIGIT_NUMBER,
   output logic [NUM_DIGITS-1:0]     o_DIGIT_ENABLE,
   output logic                      o_DOT,
   output logic                      o_FRAME_DONE
);

   localparam int MAX_CYCLES = (SHOW_CYCLES > GUARD_CYCLES) ? SHOW_CYCLES : GUARD_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);
   localparam int IW         = $clog2(NUM_DIGITS);

   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYCLES - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

   typedef enum logic {
      S_GUARD = 1'b0,
      S_SHOW  = 1'b1
   } state_t;

   state_t                        state_q, state_d;
   logic [IW-1:0]                 idx_q, idx_d;
   logic [CW-1:0]                 cnt_q, cnt_d;

   logic [NUM_DIGITS-1:0][3:0]    disp_val_q;
   logic [NUM_DIGITS-1:0]         disp_dot_q;
   logic [NUM_DIGITS-1:0][3:0]    pend_val_q;
   logic [NUM_DIGITS-1:0]         pend_dot_q;
   logic                          pend_flag_q;
   logic                          frame_done_q;

   logic                          w_boundary;
   logic                          w_nonzero_above;
   logic                          w_blank;
   logic [NUM_DIGITS-1:0]         w_en_act;
   logic                          w_dot_act;

   // Scan sequencer registers: state, digit index and per-interval counter
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         state_q <= S_GUARD;
         idx_q   <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state logic: GUARD -> SHOW on the same digit, SHOW -> GUARD on the next
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      cnt_d      = cnt_q + 1'b1;
      w_boundary = 1'b0;
      case (state_q)
         S_GUARD: begin
            if (cnt_q == GUARD_LAST) begin
               state_d = S_SHOW;
               cnt_d   = '0;
            end
         end
         S_SHOW: begin
            if (cnt_q == SHOW_LAST) begin
               state_d = S_GUARD;
               cnt_d   = '0;
               if (idx_q == IDX_LAST) begin
                  idx_d      = '0;
                  w_boundary = 1'b1;
               end else begin
                  idx_d = idx_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = S_GUARD;
            idx_d   = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Double buffer: loads always land in pending; display swaps only at a frame boundary
   always_ff @(posedge i_CLK) begin
      if (i_RESET) begin
         disp_val_q   <= '0;
         disp_dot_q   <= '0;
         pend_val_q   <= '0;
         pend_dot_q   <= '0;
         pend_flag_q  <= 1'b0;
         frame_done_q <= 1'b0;
      end else begin
         frame_done_q <= w_boundary;
         if (w_boundary && pend_flag_q) begin
            disp_val_q <= pend_val_q;
            disp_dot_q <= pend_dot_q;
         end
         // A load coinciding with the boundary keeps the flag so it is applied next frame
         if (i_LOAD) begin
            pend_val_q  <= i_VALUE;
            pend_dot_q  <= i_DOT_MASK;
            pend_flag_q <= 1'b1;
         end else if (w_boundary) begin
            pend_flag_q <= 1'b0;
         end
      end
   end

   // Leading-zero blanking: digit is blank when it and every higher nibble are zero
   always_comb begin
      w_nonzero_above = 1'b0;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if ((k >= int'(idx_q)) && (disp_val_q[k] != 4'd0)) begin
            w_nonzero_above = 1'b1;
         end
      end
      w_blank = i_BLANK_LEADING && (idx_q != '0) && !w_nonzero_above;
   end

   // Output decode in active-high form, then polarity applied combinationally
   always_comb begin
      w_en_act  = '0;
      w_dot_act = 1'b0;
      if ((state_q == S_SHOW) && !w_blank) begin
         w_en_act[idx_q] = 1'b1;
         w_dot_act       = disp_dot_q[idx_q];
      end
      o_DIGIT_ENABLE = i_COMMON_ANOD ? ~w_en_act  : w_en_act;
      o_DOT          = i_COMMON_ANOD ? ~w_dot_act : w_dot_act;
      // Nibble is presented during GUARD too, so the segment decode settles early
      o_DIGIT_NUMBER = disp_val_q[idx_q];
      o_FRAME_DONE   = frame_done_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scanner.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seven_segment_scanner
//  Description : Directed self-checking bench for seven_segment_scanner with
//                NUM_DIGITS=4, SHOW_CYCLES=8, GUARD_CYCLES=2 (40-cycle frame).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scanner;

   localparam int ND    = 4;
   localparam int SHOWC = 8;
   localparam int GUARC = 2;
   localparam int SLOT  = SHOWC + GUARC;
   localparam int FRAME = ND * SLOT;

   logic            clk = 1'b0;
   logic            rst;
   logic            load;
   logic [15:0]     val;
   logic [3:0]      dm;
   logic            blank;
   logic            ca;
   logic [3:0]      num;
   logic [3:0]      en;
   logic            dot;
   logic            fd;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   seven_segment_scanner #(
      .NUM_DIGITS  (ND),
      .SHOW_CYCLES (SHOWC),
      .GUARD_CYCLES(GUARC)
   ) dut (
      .i_CLK          (clk),
      .i_RESET        (rst),
      .i_LOAD         (load),
      .i_VALUE        (val),
      .i_DOT_MASK     (dm),
      .i_BLANK_LEADING(blank),
      .i_COMMON_ANOD  (ca),
      .o_DIGIT_NUMBER (num),
      .o_DIGIT_ENABLE (en),
      .o_DOT          (dot),
      .o_FRAME_DONE   (fd)
   );

   always #5 clk = ~clk;

   // ---------------- reference model (cycle index since reset release) -----
   function automatic bit m_blank(input logic [15:0] v, input int d, input logic bl);
      if (!bl || d == 0) return 1'b0;
      for (int k = d; k < ND; k++) if (v[k*4 +: 4] != 4'd0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [3:0] m_en(input int c, input logic [15:0] v, input logic bl);
      int p = c % FRAME;
      int d = p / SLOT;
      logic [3:0] r = 4'b0000;
      if ((p % SLOT) >= GUARC && !m_blank(v, d, bl)) r[d] = 1'b1;
      return r;
   endfunction

   function automatic logic m_dot(input int c, input logic [15:0] v, input logic [3:0] dmk, input logic bl);
      int p = c % FRAME;
      int d = p / SLOT;
      return ((p % SLOT) >= GUARC) && !m_blank(v, d, bl) && dmk[d];
   endfunction

   function automatic logic [3:0] m_num(input int c, input logic [15:0] v);
      int d = (c % FRAME) / SLOT;
      return v[d*4 +: 4];
   endfunction

   function automatic logic m_fd(input int c);
      return (c > 0) && ((c % FRAME) == 0);
   endfunction

   // ---------------- stimulus primitives -----------------------------------
   task automatic do_reset();
      @(negedge clk);
      rst  = 1'b1;
      load = 1'b0;
      @(negedge clk);
      rst  = 1'b0;
      cyc  = 0;
   endtask

   task automatic next();
      @(negedge clk);
      cyc++;
   endtask

   // ---------------- scenarios ---------------------------------------------
   task automatic test_reset();
      ca = 1'b0; blank = 1'b0;
      @(negedge clk);
      rst = 1'b1; load = 1'b1; val = 16'hFFFF; dm = 4'hF;
      @(negedge clk);
      n_tests++;
      if (en !== 4'b0000 || dot !== 1'b0 || num !== 4'd0 || fd !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_state: en=%b dot=%b num=%h fd=%b, want 0000 0 0 0", en, dot, num, fd);
      end
      ca = 1'b1; #1;
      n_tests++;
      if (en !== 4'b1111 || dot !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_polarity: en=%b dot=%b, want 1111 1", en, dot);
      end
      ca = 1'b0;
      rst = 1'b0; load = 1'b0; cyc = 0;
      // the load issued under reset must be discarded
      while (cyc < 50) begin
         n_tests++;
         if (num !== 4'd0 || fd !== m_fd(cyc)) begin
            n_fail++;
            $display("FAIL reset_discard c=%0d: num=%h fd=%b, want 0 %b", cyc, num, fd, m_fd(cyc));
         end
         next();
      end
   endtask

   task automatic test_load_frame();
      logic [15:0] v;
      ca = 1'b0; blank = 1'b0; dm = 4'b0000;
      do_reset();
      while (cyc < 2*FRAME) begin
         v = (cyc < FRAME) ? 16'h0000 : 16'h1234;
         n_tests++;
         if (en !== m_en(cyc, v, 1'b0) || num !== m_num(cyc, v) || dot !== 1'b0 || fd !== m_fd(cyc)) begin
            n_fail++;
            $display("FAIL load_frame c=%0d: en=%b num=%h dot=%b fd=%b, want %b %h 0 %b",
                     cyc, en, num, dot, fd, m_en(cyc, v, 1'b0), m_num(cyc, v), m_fd(cyc));
         end
         if (cyc == 5) begin load = 1'b1; val = 16'h1234; end
         next();
         load = 1'b0;
      end
   endtask

   task automatic test_overwrite();
      logic [15:0] v;
      ca = 1'b0; blank = 1'b0; dm = 4'b0000;
      do_reset();
      while (cyc < 2*FRAME) begin
         v = (cyc < FRAME) ? 16'h0000 : 16'h5678;
         n_tests++;
         if (en !== m_en(cyc, v, 1'b0) || num !== m_num(cyc, v) || fd !== m_fd(cyc)) begin
            n_fail++;
            $display("FAIL overwrite c=%0d: en=%b num=%h fd=%b, want %b %h %b",
                     cyc, en, num, fd, m_en(cyc, v, 1'b0), m_num(cyc, v), m_fd(cyc));
         end
         if (cyc == 10) begin load = 1'b1; val = 16'hABCD; end
         if (cyc == 30) begin load = 1'b1; val = 16'h5678; end
         next();
         load = 1'b0;
      end
   endtask

   task automatic test_boundary_load();
      logic [15:0] v;
      ca = 1'b0; blank = 1'b0; dm = 4'b0000;
      do_reset();
      while (cyc < 3*FRAME) begin
         v = (cyc < FRAME) ? 16'h0000 : (cyc < 2*FRAME) ? 16'h1234 : 16'h9876;
         n_tests++;
         if (en !== m_en(cyc, v, 1'b0) || num !== m_num(cyc, v) || fd !== m_fd(cyc)) begin
            n_fail++;
            $display("FAIL boundary_load c=%0d: en=%b num=%h fd=%b, want %b %h %b",
                     cyc, en, num, fd, m_en(cyc, v, 1'b0), m_num(cyc, v), m_fd(cyc));
         end
         if (cyc == 5)         begin load = 1'b1; val = 16'h1234; end
         if (cyc == FRAME - 1) begin load = 1'b1; val = 16'h9876; end
         next();
         load = 1'b0;
      end
   endtask

   task automatic test_blank();
      logic [15:0] v;
      ca = 1'b0; blank = 1'b1; dm = 4'b1111;
      do_reset();
      while (cyc < 3*FRAME) begin
         v = (cyc < 2*FRAME) ? 16'h0040 : 16'h0000;
         if (cyc >= FRAME) begin
            n_tests++;
            if (en !== m_en(cyc, v, 1'b1) || num !== m_num(cyc, v) || dot !== m_dot(cyc, v, 4'hF, 1'b1)) begin
               n_fail++;
               $display("FAIL blank c=%0d: en=%b num=%h dot=%b, want %b %h %b",
                        cyc, en, num, dot, m_en(cyc, v, 1'b1), m_num(cyc, v), m_dot(cyc, v, 4'hF, 1'b1));
            end
         end
         if (cyc == 0)  begin load = 1'b1; val = 16'h0040; end
         if (cyc == 45) begin load = 1'b1; val = 16'h0000; end
         next();
         load = 1'b0;
      end
      blank = 1'b0;
   endtask

   task automatic test_polarity();
      ca = 1'b1; blank = 1'b0;
      do_reset();
      load = 1'b1; val = 16'h0000; dm = 4'b0001;
      next();
      load = 1'b0;
      while (cyc < 2*FRAME) begin
         if (cyc >= FRAME) begin
            n_tests++;
            if (en !== ~m_en(cyc, 16'h0, 1'b0) || dot !== ~m_dot(cyc, 16'h0, 4'b0001, 1'b0)) begin
               n_fail++;
               $display("FAIL polarity c=%0d: en=%b dot=%b, want %b %b",
                        cyc, en, dot, ~m_en(cyc, 16'h0, 1'b0), ~m_dot(cyc, 16'h0, 4'b0001, 1'b0));
            end
         end
         if (cyc == FRAME + 5) begin
            n_tests++;
            if (en !== 4'b1110 || dot !== 1'b0) begin
               n_fail++;
               $display("FAIL polarity_show0: en=%b dot=%b, want 1110 0", en, dot);
            end
            ca = 1'b0; #1;
            n_tests++;
            if (en !== 4'b0001 || dot !== 1'b1) begin
               n_fail++;
               $display("FAIL polarity_flip: en=%b dot=%b, want 0001 1", en, dot);
            end
            ca = 1'b1;
         end
         next();
      end
      ca = 1'b0;
   endtask

   task automatic test_reset_mid_show();
      ca = 1'b0; blank = 1'b0; dm = 4'b0000;
      do_reset();
      load = 1'b1; val = 16'h1234;
      next();
      load = 1'b0;
      while (cyc < FRAME + 2*SLOT + 5) next();
      n_tests++;
      if (en !== 4'b0100 || num !== 4'h2) begin
         n_fail++;
         $display("FAIL midshow_pre: en=%b num=%h, want 0100 2", en, num);
      end
      rst = 1'b1; load = 1'b1; val = 16'hFFFF; dm = 4'hF;
      @(negedge clk);
      rst = 1'b0; load = 1'b0; cyc = 0;
      n_tests++;
      if (en !== 4'b0000 || num !== 4'd0 || dot !== 1'b0 || fd !== 1'b0) begin
         n_fail++;
         $display("FAIL midshow_reset: en=%b num=%h dot=%b fd=%b, want 0000 0 0 0", en, num, dot, fd);
      end
      while (cyc < FRAME + SLOT) begin
         n_tests++;
         if (num !== 4'd0 || dot !== 1'b0 || en !== m_en(cyc, 16'h0, 1'b0) || fd !== m_fd(cyc)) begin
            n_fail++;
            $display("FAIL midshow_after c=%0d: en=%b num=%h dot=%b fd=%b, want %b 0 0 %b",
                     cyc, en, num, dot, fd, m_en(cyc, 16'h0, 1'b0), m_fd(cyc));
         end
         next();
      end
   endtask

   initial begin
      rst = 1'b1; load = 1'b0; val = 16'h0; dm = 4'h0; blank = 1'b0; ca = 1'b0;
      test_reset();
      test_load_frame();
      test_overwrite();
      test_boundary_load();
      test_blank();
      test_polarity();
      test_reset_mid_show();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
